// File: rtl/jam_cost_arbiter.sv
`timescale 1ns/1ps
// jam_cost_arbiter: round-robin sharing of the cost-table port between two evaluators,
// summing the eight lookups of each granted assignment.
module jam_cost_arbiter #(
  parameter int NW = 8,
  parameter int IW = 3,
  parameter int CW = 7,
  parameter int SW = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  input  logic [NW*IW-1:0]     req0_perm,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [NW*IW-1:0]     req1_perm,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [SW-1:0]        rsp_sum,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        W,
  output logic [IW-1:0]        J,
  output logic                 cost_rd,
  input  logic [CW-1:0]        Cost
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESP} state_t;
  state_t            state;
  logic [NW*IW-1:0]  perm;
  logic [IW-1:0]     k;
  logic [SW-1:0]     sum;
  logic              id, last_grant, idle, fetch, g1;
  assign idle       = state == IDLE;
  assign fetch      = state == FETCH;
  // req1 wins only when alone or when req0 was served last
  assign g1         = req1_valid && (!req0_valid || !last_grant);
  assign req1_ready = idle && g1;
  assign req0_ready = idle && req0_valid && !g1;
  assign cost_rd    = fetch;
  assign W          = fetch ? k : '0;
  assign J          = fetch ? perm[k*IW +: IW] : '0;
  assign rsp_valid  = state == RESP;
  assign rsp_id     = id;
  assign rsp_sum    = sum;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      perm       <= '0;
      k          <= '0;
      sum        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          perm       <= req1_ready ? req1_perm : req0_perm;
          id         <= req1_ready;
          last_grant <= req1_ready;
          sum        <= '0;
          k          <= '0;
          state      <= FETCH;
        end
        FETCH: begin
          // Cost lags W/J by one cycle, so the first fetch cycle has nothing to add
          if (k != '0) sum <= sum + SW'(Cost);
          k <= k + 1'b1;
          if (k == IW'(NW - 1)) state <= DRAIN;
        end
        DRAIN: begin
          sum   <= sum + SW'(Cost);
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jam_cost_arbiter.sv
`timescale 1ns/1ps
// tb_jam_cost_arbiter: randomized requesters with a scoreboard checking grants, lookups and sums
module tb_jam_cost_arbiter;
  logic        CLK, RST;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_perm, req1_perm;
  logic        rsp_valid, rsp_id, rsp_ready, cost_rd;
  logic [9:0]  rsp_sum;
  logic [2:0]  W, J;
  logic [6:0]  Cost;

  jam_cost_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_perm(req0_perm), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_perm(req1_perm), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .W(W), .J(J), .cost_rd(cost_rd), .Cost(Cost)
  );

  typedef struct { logic id; logic [9:0] sum; } exp_t;
  exp_t        q[$];
  logic [6:0]  tbl [8][8];
  int          checks = 0, errors = 0;
  int          cyc = 0, fl = 0, fk = 0, hs_cyc = 0, prev_hs = -1, bp = 0;
  logic [23:0] fperm;
  logic        lastg = 1, rv_d = 0, tight = 0;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // cost table: data appears the cycle after the lookup, junk otherwise
  always @(posedge CLK) Cost <= cost_rd ? tbl[W][J] : 7'($urandom);

  always begin
    @(posedge CLK); #1;
    rsp_ready = bp == 0 ? 1'b1 : bp == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] model(input logic [23:0] p);
    int s = 0;
    for (int w = 0; w < 8; w++) s += tbl[w][p[3*w +: 3]];
    return 10'(s);
  endfunction

  task automatic set_tbl(input int mode);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        tbl[w][j] = mode == 0 ? 7'(10*w + j) : mode == 1 ? 7'd127 : 7'($urandom);
  endtask

  // monitor: checks lookups, grants and responses against the scoreboard
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      q.delete(); fl = 0; lastg = 1; rv_d = 0; prev_hs = -1;
    end else begin
      chk(!(req0_ready && req1_ready), "single_ready", {req0_ready, req1_ready}, 0);
      if (fl > 0) begin
        chk(cost_rd && W == 3'(fk) && J == fperm[3*fk +: 3] && !req0_ready && !req1_ready,
            "lookup", {req0_ready, req1_ready, cost_rd, W, J}, {3'b001, 3'(fk), fperm[3*fk +: 3]});
        fk++; fl--;
      end else
        chk(!cost_rd && W == 0 && J == 0, "no_lookup", {cost_rd, W, J}, 0);
      if (rsp_valid) begin
        if (q.size() == 0) chk(0, "rsp_unexpected", rsp_sum, 0);
        else begin
          chk(rsp_id == q[0].id && rsp_sum == q[0].sum, "rsp", {rsp_id, rsp_sum}, {q[0].id, q[0].sum});
          chk(!req0_ready && !req1_ready, "ready_in_resp", {req0_ready, req1_ready}, 0);
          if (!rv_d) chk(cyc - hs_cyc == 10, "latency", cyc - hs_cyc, 10);
          if (rsp_ready) void'(q.pop_front());
        end
      end
      rv_d = rsp_valid && !rsp_ready;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        logic g, e;
        g = req1_valid && req1_ready;
        e = (req0_valid && req1_valid) ? !lastg : req1_valid;
        chk(g == e, "grant", g, e);
        lastg = g;
        fperm = g ? req1_perm : req0_perm;
        q.push_back('{g, model(fperm)});
        fl = 8; fk = 0;
        if (prev_hs >= 0) begin
          chk(cyc - prev_hs >= 11, "spacing_min", cyc - prev_hs, 11);
          if (tight) chk(cyc - prev_hs == 11, "spacing", cyc - prev_hs, 11);
        end
        prev_hs = cyc; hs_cyc = cyc;
      end
    end
  end

  task automatic requester(input bit id, input int n, input int gap, input bit fixed, input logic [23:0] fp);
    int t;
    @(posedge CLK); #1;
    for (int i = 0; i < n; i++) begin
      if (id) begin req1_valid = 1; req1_perm = fixed ? fp : 24'($urandom); end
      else    begin req0_valid = 1; req0_perm = fixed ? fp : 24'($urandom); end
      t = 0;
      do begin @(negedge CLK); t++; end
      while (!(id ? req1_ready : req0_ready) && t < 2000);
      if (t >= 2000) chk(0, "grant_timeout", id, 1);
      @(posedge CLK); #1;
      if (id) begin req1_valid = 0; req1_perm = 24'($urandom); end
      else    begin req0_valid = 0; req0_perm = 24'($urandom); end
      repeat ($urandom_range(0, gap)) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || fl != 0) && t < 500) begin @(negedge CLK); t++; end
    chk(t < 500, "drain_timeout", t, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask

  logic [23:0] ident, rev;

  initial begin
    for (int k = 0; k < 8; k++) begin ident[3*k +: 3] = 3'(k); rev[3*k +: 3] = 3'(7 - k); end
    RST = 1; req0_valid = 0; req1_valid = 0; req0_perm = 0; req1_perm = 0; rsp_ready = 1;
    set_tbl(0);
    #1;
    chk({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, W, J, cost_rd} == 0, "reset_outputs",
        {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, W, J, cost_rd}, 0);
    repeat (3) @(negedge CLK);
    RST = 0;
    requester(0, 1, 0, 1, ident);
    drain();
    do_reset();
    fork
      requester(0, 1, 0, 1, ident);
      requester(1, 1, 0, 1, rev);
    join
    drain();
    set_tbl(2);
    tight = 1; prev_hs = -1;
    fork
      requester(0, 4, 0, 0, 0);
      requester(1, 4, 0, 0, 0);
    join
    drain();
    tight = 0;
    set_tbl(1);
    bp = 2;
    requester(1, 1, 0, 0, 0);
    begin
      int t = 0;
      while (!rsp_valid && t < 100) begin @(negedge CLK); t++; end
      chk(t < 100, "rsp_timeout", t, 0);
    end
    fork
      begin repeat (5) @(posedge CLK); #1; bp = 0; end
      requester(0, 1, 0, 0, 0);
    join
    drain();
    set_tbl(2);
    bp = 1;
    fork
      requester(0, 10, 15, 0, 0);
      requester(1, 10, 15, 0, 0);
    join
    drain();
    bp = 0;
    set_tbl(0);
    requester(0, 1, 0, 0, 0);
    begin
      int t = 0;
      do begin @(negedge CLK); t++; end while (!(cost_rd && W == 3'd4) && t < 100);
      chk(t < 100, "fetch4_timeout", t, 0);
    end
    #1 RST = 1;
    #1;
    chk({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, W, J, cost_rd} == 0, "async_reset",
        {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, W, J, cost_rd}, 0);
    repeat (2) @(negedge CLK);
    #1 RST = 0;
    repeat (15) @(negedge CLK);
    requester(1, 1, 0, 0, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jam_cost_arbiter.md
Name: jam_cost_arbiter

Overview:
- Shares the single external cost-table port (W/J in, Cost back) between two permutation evaluators in the job-assignment engine.
- Each requester hands over one complete worker-to-job assignment.
- The block sequences the eight table lookups, accumulates the total cost and returns the sum with the requester ID.
- Round-robin arbitration gives both evaluators fair access to the table.

Parameters:
- NW, 8, number of workers/jobs (lookups per assignment)
- IW, 3, worker/job index width
- CW, 7, cost word width
- SW, 10, accumulated sum width (NW*(2^CW-1)=1016 fits; no overflow possible)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an assignment
- req0_perm  in  24  job for worker k in bits [3k+2:3k]
- req0_ready  out  1  assignment accepted this cycle when high with req0_valid
- req1_valid  in  1  requester 1, same as above
- req1_perm  in  24  requester 1 assignment
- req1_ready  out  1  requester 1 accept
- rsp_valid  out  1  result available
- rsp_id  out  1  requester the result belongs to
- rsp_sum  out  10  total cost of the assignment
- rsp_ready  in  1  consumer takes result
- W  out  3  worker index to cost table
- J  out  3  job index to cost table
- cost_rd  out  1  W/J carry a valid lookup this cycle
- Cost  in  7  table data, valid the cycle after W/J are driven

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0 (ready, rsp_valid, rsp_id, rsp_sum, W, J, cost_rd).
  - Internal sum=0, counter=0, last_grant=1, so req0 wins the first tie.
- States: IDLE, FETCH, DRAIN, RESP.
- IDLE:
  - Grant is combinational. If exactly one requester is valid, its ready=1.
  - If both are valid, grant the one not equal to last_grant.
  - At most one ready is high per cycle; ready is never high outside IDLE.
  - On handshake: latch perm and id, set last_grant=id, clear sum, clear counter k, go to FETCH.
- FETCH (8 cycles, k=0..7):
  - cost_rd=1, W=k, J=perm[3k+2:3k].
  - From the 2nd FETCH cycle on, sum += Cost, zero-extended to 10 bits.
  - After k=7, go to DRAIN.
- DRAIN (1 cycle):
  - cost_rd=0, W=J=0.
  - sum += Cost (the last lookup), then go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id stay stable until handshake.
  - On rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
- Outside FETCH, W=J=0 and cost_rd=0.
- Latency:
  - Handshake in cycle T → FETCH T+1..T+8, DRAIN T+9, rsp_valid high from T+10.
  - With rsp_ready held high, the next grant is at T+11 at the earliest (11-cycle throughput).
- Backpressure: while in RESP, neither requester is granted; requests wait with valid held (requesters keep perm stable).
- Valid dropped by a requester before grant: no grant, no state change.
- Both request every time: grants strictly alternate 0,1,0,1…
- Reset mid-operation: the in-flight assignment is discarded; no response is produced; the arbiter restarts with req0 priority.
- The latched perm is used for all lookups; changes on req*_perm after the handshake have no effect.

Test Plan:
- Single request, Cost model = 10*W+J. req0_perm identity (J=k for worker k) → W/J sequence (0,0)..(7,7) on cycles T+1..T+8; rsp_valid at T+10 with rsp_id=0, rsp_sum=308.
- Simultaneous req0/req1 right after reset: req0 perm identity, req1 perm reversed (J=7-k), same Cost model. Expected: req0 granted first (sum 308); req1 granted after the first response, rsp_id=1, rsp_sum=10*28+28=308 with J sequence 7..0.
- Both requesters hold valid for 4 jobs, rsp_ready=1 → grant order 0,1,0,1; handshakes spaced exactly 11 cycles apart.
- Cost tied to 127, any perm → rsp_sum=1016, no wrap. With rsp_ready low for 5 cycles: rsp_valid, rsp_sum and rsp_id stay stable, both ready outputs stay 0, and the accept happens the cycle after rsp_ready goes high.
- Assert RST at FETCH k=4 → all outputs 0 immediately; no rsp_valid follows. A subsequent req1-only request completes normally with the correct sum.
